alu_issue: RTL and testbench

Issue and decode front end for the RV32I ALU. It accepts one instruction at a time, together with its register operands and PC, over a valid/ready handshake. It decodes the instruction into the 6-bit ALU op code, selects the ALU operands, waits out the ALU's one-cycle registered latency, and returns the result with its destination register over a second valid/ready handshake. It sits between the register-read stage and writeback, and is the only driver of the ALU's op/in_a/in_b inputs.

---
 rtl/alu_issue.sv | 205 ++++++++++++++++++++
 tb/tb_alu_issue.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue/decode front end for the RV32I ALU: accepts one instruction, drives the
// ALU for a single cycle, waits out its registered latency and returns the result.
module alu_issue #(
    parameter int XLEN = 32,
    parameter int OPW  = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out,
    input  logic [3:0]      alu_flag,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic [3:0]      res_flags,
    output logic            res_illegal
);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_OR    = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_AND   = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_SRL   = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_SRA   = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_SLTU  = OPW'(8'h09);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(8'h0A);
    localparam logic [OPW-1:0] OP_LUI   = OPW'(8'h0B);
    localparam logic [OPW-1:0] OP_AUIPC = OPW'(8'h0C);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t            state_q;
    logic              in_ready_q, res_valid_q, res_illegal_q;
    logic [OPW-1:0]    alu_op_q;
    logic [XLEN-1:0]   alu_a_q, alu_b_q, res_data_q;
    logic [4:0]        res_rd_q;
    logic [3:0]        res_flags_q;

    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   imm_i, imm_u, shamt_r, shamt_i;
    logic              is_op;
    logic [OPW-1:0]    op_d;
    logic [XLEN-1:0]   a_d, b_d;
    logic              illegal_d;
    logic              unused_rs1_idx;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign is_op   = (opcode == OPC_OP);
    assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_u   = {{(XLEN-20){1'b0}}, instr[31:12]};
    assign shamt_r = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
    assign shamt_i = {{(XLEN-5){1'b0}}, instr[24:20]};
    // Register indices arrive already resolved into rs1_val/rs2_val.
    assign unused_rs1_idx = ^instr[19:15];

    always_comb begin
        op_d      = OP_ADD;
        a_d       = '0;
        b_d       = '0;
        illegal_d = 1'b0;
        case (opcode)
            OPC_OP, OPC_IMM: begin
                a_d = rs1_val;
                b_d = is_op ? rs2_val : imm_i;
                case (funct3)
                    3'b000: op_d = (is_op && funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                    3'b001: begin
                        op_d = OP_SLL;
                        b_d  = is_op ? shamt_r : shamt_i;
                    end
                    3'b010: op_d = OP_SLT;
                    3'b011: op_d = OP_SLTU;
                    3'b100: op_d = OP_XOR;
                    3'b101: begin
                        op_d = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                        b_d  = is_op ? shamt_r : shamt_i;
                    end
                    3'b110: op_d = OP_OR;
                    3'b111: op_d = OP_AND;
                endcase
                // funct7 only carries meaning for sub/sra and the immediate shifts.
                if (is_op)
                    illegal_d = !(funct7 == F7_BASE ||
                                  (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
                else if (funct3 == 3'b001)
                    illegal_d = (funct7 != F7_BASE);
                else if (funct3 == 3'b101)
                    illegal_d = !(funct7 == F7_BASE || funct7 == F7_ALT);
            end
            OPC_LUI: begin
                op_d = OP_LUI;
                b_d  = imm_u;
            end
            OPC_AUIPC: begin
                op_d = OP_AUIPC;
                a_d  = pc;
                b_d  = imm_u;
            end
            OPC_JAL: begin
                op_d = OP_JAL;
                a_d  = pc;
            end
            OPC_JALR: begin
                op_d      = OP_JAL;
                a_d       = pc;
                illegal_d = (funct3 != 3'b000);
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_illegal_q <= 1'b0;
            alu_op_q      <= OP_ADD;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_flags_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (illegal_d) begin
                            // Never reaches the ALU; answer straight away.
                            state_q       <= RESP;
                            res_valid_q   <= 1'b1;
                            res_illegal_q <= 1'b1;
                            res_data_q    <= '0;
                            res_rd_q      <= '0;
                            res_flags_q   <= '0;
                        end else begin
                            state_q  <= EXEC;
                            alu_op_q <= op_d;
                            alu_a_q  <= a_d;
                            alu_b_q  <= b_d;
                            res_rd_q <= instr[11:7];
                        end
                    end
                end
                EXEC: begin
                    state_q  <= CAPT;
                    alu_op_q <= OP_ADD;
                    alu_a_q  <= '0;
                    alu_b_q  <= '0;
                end
                CAPT: begin
                    state_q     <= RESP;
                    res_data_q  <= alu_out;
                    res_flags_q <= alu_flag;
                    res_valid_q <= 1'b1;
                end
                RESP: begin
                    if (res_ready) begin
                        state_q       <= IDLE;
                        res_valid_q   <= 1'b0;
                        res_illegal_q <= 1'b0;
                        in_ready_q    <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign res_flags   = res_flags_q;
    assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the alu_* ports, RV32I reference model,
// directed vectors plus randomized instruction streams.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0, pc = '0, rs1_val = '0, rs2_val = '0;
    logic [5:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_out = '0;
    logic [3:0]  alu_flag = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic [3:0]  res_flags;
    logic        res_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32), .OPW(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rd(res_rd),
        .res_flags(res_flags), .res_illegal(res_illegal)
    );

    // Behavioural ALU with a one-cycle registered result.
    function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'h00: return a + b;
            6'h01: return a - b;
            6'h02: return a ^ b;
            6'h03: return a | b;
            6'h04: return a & b;
            6'h05: return a << b[4:0];
            6'h06: return a >> b[4:0];
            6'h07: return $signed(a) >>> b[4:0];
            6'h08: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h09: return (a < b) ? 32'd1 : 32'd0;
            6'h0A: return a + 32'd4;
            6'h0B: return b << 12;
            6'h0C: return a + (b << 12);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] flag_of(input logic [31:0] r);
        return {2'b00, r[31], (r == 32'd0)};
    endfunction

    always @(posedge clk) begin
        alu_out  <= alu_model(alu_op, alu_a, alu_b);
        alu_flag <= flag_of(alu_model(alu_op, alu_a, alu_b));
    end

    // Reference: architectural RV32I meaning of the instruction plus the operands the ALU must see.
    task automatic ref_exec(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] r1,
                            input logic [31:0] r2, output logic ill, output logic [5:0] op,
                            output logic [31:0] a, output logic [31:0] b, output logic [31:0] res);
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] imm, uimm, src2;
        logic [4:0]  sh;
        logic        is_r;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        uimm = {ins[31:12], 12'b0};
        ill = 1'b1; op = 6'h00; a = '0; b = '0; res = '0;
        if (opc == 7'h33 || opc == 7'h13) begin
            is_r = (opc == 7'h33);
            src2 = is_r ? r2 : imm;
            sh   = is_r ? r2[4:0] : ins[24:20];
            a = r1; b = src2;
            case (f3)
                3'd0: if (is_r && f7 == 7'h20) begin op = 6'h01; res = r1 - r2; ill = 1'b0; end
                      else begin op = 6'h00; res = r1 + src2; ill = is_r && f7 != 7'h00; end
                3'd1: begin op = 6'h05; b = {27'b0, sh}; res = r1 << sh; ill = (f7 != 7'h00); end
                3'd2: begin op = 6'h08; res = ($signed(r1) < $signed(src2)) ? 32'd1 : 32'd0; ill = is_r && f7 != 7'h00; end
                3'd3: begin op = 6'h09; res = (r1 < src2) ? 32'd1 : 32'd0; ill = is_r && f7 != 7'h00; end
                3'd4: begin op = 6'h02; res = r1 ^ src2; ill = is_r && f7 != 7'h00; end
                3'd5: begin
                    b = {27'b0, sh};
                    if (f7 == 7'h20) begin op = 6'h07; res = $signed(r1) >>> sh; ill = 1'b0; end
                    else begin op = 6'h06; res = r1 >> sh; ill = (f7 != 7'h00); end
                end
                3'd6: begin op = 6'h03; res = r1 | src2; ill = is_r && f7 != 7'h00; end
                default: begin op = 6'h04; res = r1 & src2; ill = is_r && f7 != 7'h00; end
            endcase
        end else if (opc == 7'h37) begin
            ill = 1'b0; op = 6'h0B; b = {12'b0, ins[31:12]}; res = uimm;
        end else if (opc == 7'h17) begin
            ill = 1'b0; op = 6'h0C; a = pcv; b = {12'b0, ins[31:12]}; res = pcv + uimm;
        end else if (opc == 7'h6F || (opc == 7'h67 && f3 == 3'd0)) begin
            ill = 1'b0; op = 6'h0A; a = pcv; res = pcv + 32'd4;
        end
        if (ill) begin op = 6'h00; a = '0; b = '0; res = '0; end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned k, j;
        w = $urandom;
        k = $urandom_range(0, 9);
        j = $urandom_range(0, 3);
        case (k)
            0, 1: begin
                w[6:0] = 7'h33;
                w[31:25] = (j < 2) ? 7'h00 : (j == 2) ? 7'h20 : w[31:25];
            end
            2, 3: begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5)
                    w[31:25] = (j < 2) ? 7'h00 : (j == 2) ? 7'h20 : w[31:25];
            end
            4: w[6:0] = 7'h37;
            5: w[6:0] = 7'h17;
            6: w[6:0] = 7'h6F;
            7: begin w[6:0] = 7'h67; if (j != 0) w[14:12] = 3'd0; end
            8: w[6:0] = (j == 0) ? 7'h03 : (j == 1) ? 7'h23 : (j == 2) ? 7'h63 : 7'h73;
            default: ;
        endcase
        return w;
    endfunction

    // Observations gathered by run_one for the calling test to judge.
    logic        obs_accept, obs_busy, obs_done_vld, obs_done_rdy, obs_ill;
    logic [5:0]  obs_op;
    logic [31:0] obs_a, obs_b, obs_data;
    logic [4:0]  obs_rd;
    logic [3:0]  obs_flags;
    int          obs_lat, obs_nonidle, obs_unstable;

    task automatic run_one(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] r1,
                           input logic [31:0] r2, input int hold);
        int guard;
        logic [41:0] snap;
        in_valid = 1'b1; instr = ins; pc = pcv; rs1_val = r1; rs2_val = r2;
        guard = 0;
        while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        obs_accept = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0; instr = $urandom; pc = $urandom; rs1_val = $urandom; rs2_val = $urandom;
        obs_op = alu_op; obs_a = alu_a; obs_b = alu_b; obs_busy = !in_ready;
        obs_lat = 0; obs_nonidle = 0; obs_unstable = 0;
        while (!res_valid && obs_lat < 8) begin
            @(posedge clk); #1;
            obs_lat++;
            if ({alu_op, alu_a, alu_b} !== 70'd0) obs_nonidle++;
        end
        obs_data = res_data; obs_rd = res_rd; obs_flags = res_flags; obs_ill = res_illegal;
        snap = {res_valid, res_data, res_rd, res_flags};
        repeat (hold) begin
            @(posedge clk); #1;
            if ({res_valid, res_data, res_rd, res_flags} !== snap || res_illegal !== obs_ill) obs_unstable++;
            if ({alu_op, alu_a, alu_b} !== 70'd0) obs_nonidle++;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        obs_done_vld = res_valid; obs_done_rdy = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({in_ready, res_valid, res_illegal} !== 3'b000) begin bad++;
            $display("FAIL reset_ctrl got=%b want=000", {in_ready, res_valid, res_illegal}); end
        total++; if ({alu_op, alu_a, alu_b} !== 70'd0) begin bad++;
            $display("FAIL reset_alu got op=%h a=%h b=%h want zeros", alu_op, alu_a, alu_b); end
        total++; if ({res_data, res_rd, res_flags} !== 41'd0) begin bad++;
            $display("FAIL reset_res got data=%h rd=%0d flags=%h want zeros", res_data, res_rd, res_flags); end
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++;
            $display("FAIL reset_release_early in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL reset_release in_ready got=%b want=1", in_ready); end
    endtask

    typedef struct {
        logic [31:0] ins, pcv, r1, r2;
        logic [5:0]  op;
        logic [31:0] a, b, data;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    task automatic test_directed();
        vec_t v [7];
        int   want_lat;
        v[0] = '{32'h002081B3, 32'h100,  32'd5,        32'd7, 6'h00, 32'd5,        32'd7,        32'd12,       5'd3,  1'b0};
        v[1] = '{32'h4040D293, 32'h104,  32'h80000010, 32'd0, 6'h07, 32'h80000010, 32'h4,        32'hF8000001, 5'd5,  1'b0};
        v[2] = '{32'h123450B7, 32'h108,  32'hDEAD,     32'd1, 6'h0B, 32'd0,        32'h00012345, 32'h12345000, 5'd1,  1'b0};
        v[3] = '{32'hFFF0A113, 32'h10C,  32'hFFFFFFFE, 32'd0, 6'h08, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,        5'd2,  1'b0};
        v[4] = '{32'h00002083, 32'h110,  32'd9,        32'd9, 6'h00, 32'd0,        32'd0,        32'd0,        5'd0,  1'b1};
        v[5] = '{32'h00001517, 32'h1000, 32'd0,        32'd0, 6'h0C, 32'h1000,     32'd1,        32'h2000,     5'd10, 1'b0};
        v[6] = '{32'h008000EF, 32'h200,  32'd0,        32'd0, 6'h0A, 32'h200,      32'd0,        32'h204,      5'd1,  1'b0};
        for (int i = 0; i < 7; i++) begin
            run_one(v[i].ins, v[i].pcv, v[i].r1, v[i].r2, i % 3);
            want_lat = v[i].ill ? 0 : 2;
            total++; if ({obs_op, obs_a, obs_b} !== {v[i].op, v[i].a, v[i].b}) begin bad++;
                $display("FAIL dir%0d_drive got op=%h a=%h b=%h want op=%h a=%h b=%h", i, obs_op, obs_a, obs_b, v[i].op, v[i].a, v[i].b); end
            total++; if (obs_lat != want_lat) begin bad++;
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, obs_lat, want_lat); end
            total++; if ({obs_data, obs_rd, obs_ill} !== {v[i].data, v[i].rd, v[i].ill}) begin bad++;
                $display("FAIL dir%0d_result got data=%h rd=%0d ill=%b want data=%h rd=%0d ill=%b", i, obs_data, obs_rd, obs_ill, v[i].data, v[i].rd, v[i].ill); end
            total++; if (obs_nonidle != 0) begin bad++;
                $display("FAIL dir%0d_idle_drive got=%0d nonidle cycles want=0", i, obs_nonidle); end
            if (!v[i].ill) begin
                total++; if (obs_flags !== flag_of(v[i].data)) begin bad++;
                    $display("FAIL dir%0d_flags got=%h want=%h", i, obs_flags, flag_of(v[i].data)); end
            end
            total++; if ({obs_done_vld, obs_done_rdy} !== 2'b01) begin bad++;
                $display("FAIL dir%0d_handshake got vld,rdy=%b want=01", i, {obs_done_vld, obs_done_rdy}); end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        logic [3:0] f0;
        in_valid = 1'b1; instr = 32'h002081B3; rs1_val = 32'd5; rs2_val = 32'd7; pc = 32'h300;
        guard = 0;
        while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!res_valid && guard < 8) begin @(posedge clk); #1; guard++; end
        f0 = flag_of(32'd12);
        in_valid = 1'b1; instr = 32'h402083B3; rs1_val = 32'd9; rs2_val = 32'd4;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if ({res_valid, res_data, res_rd, res_flags, res_illegal, in_ready} !== {1'b1, 32'd12, 5'd3, f0, 1'b0, 1'b0}) begin bad++;
                $display("FAIL bp_hold%0d got vld=%b data=%h rd=%0d flags=%h ill=%b rdy=%b want 1/0000000c/3/%h/0/0",
                         c, res_valid, res_data, res_rd, res_flags, res_illegal, in_ready, f0); end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        total++; if ({res_valid, in_ready} !== 2'b01) begin bad++;
            $display("FAIL bp_release got vld,rdy=%b want=01", {res_valid, in_ready}); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if ({in_ready, alu_op, alu_a, alu_b} !== {1'b0, 6'h01, 32'd9, 32'd4}) begin bad++;
            $display("FAIL bp_second_accept got rdy=%b op=%h a=%h b=%h want 0/01/9/4", in_ready, alu_op, alu_a, alu_b); end
        guard = 0;
        while (!res_valid && guard < 8) begin @(posedge clk); #1; guard++; end
        total++; if ({res_valid, res_data, res_rd} !== {1'b1, 32'd5, 5'd7}) begin bad++;
            $display("FAIL bp_second_result got vld=%b data=%h rd=%0d want 1/5/7", res_valid, res_data, res_rd); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        int guard, seen;
        in_valid = 1'b1; instr = 32'h402083B3; rs1_val = 32'd9; rs2_val = 32'd4; pc = 32'h400;
        guard = 0;
        while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (alu_op !== 6'h01) begin bad++;
            $display("FAIL rst_mid_exec_entry op got=%h want=01", alu_op); end
        #2 rst = 1'b0;
        #1;
        total++; if ({in_ready, res_valid, res_illegal, alu_op, alu_a, alu_b, res_data, res_rd, res_flags} !== 114'd0) begin bad++;
            $display("FAIL rst_mid_async got rdy=%b vld=%b op=%h a=%h b=%h want zeros", in_ready, res_valid, alu_op, alu_a, alu_b); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL rst_mid_ready got=%b want=1", in_ready); end
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (res_valid) seen++; end
        total++; if (seen != 0) begin bad++;
            $display("FAIL rst_mid_dropped res_valid cycles got=%0d want=0", seen); end
    endtask

    task automatic test_back_to_back();
        int highs;
        in_valid = 1'b1; instr = 32'h00002083; res_ready = 1'b1;
        highs = 0;
        repeat (10) begin @(posedge clk); #1; if (res_valid) highs++; end
        total++; if (highs != 5) begin bad++;
            $display("FAIL b2b_illegal results got=%0d want=5", highs); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] ins, pcv, r1, r2, ea, eb, eres;
        logic [5:0]  eop;
        logic        eill;
        int          hold, want_lat;
        for (int n = 0; n < 80; n++) begin
            ins  = rand_instr();
            r1   = $urandom;
            r2   = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            pcv  = $urandom & 32'hFFFF_FFFC;
            hold = $urandom_range(0, 3);
            ref_exec(ins, pcv, r1, r2, eill, eop, ea, eb, eres);
            run_one(ins, pcv, r1, r2, hold);
            want_lat = eill ? 0 : 2;
            total++; if (!obs_accept || !obs_busy) begin bad++;
                $display("FAIL rnd%0d_accept got acc=%b busy=%b want 1/1 instr=%h", n, obs_accept, obs_busy, ins); end
            total++; if ({obs_op, obs_a, obs_b} !== {eop, ea, eb}) begin bad++;
                $display("FAIL rnd%0d_drive instr=%h got op=%h a=%h b=%h want op=%h a=%h b=%h", n, ins, obs_op, obs_a, obs_b, eop, ea, eb); end
            total++; if (obs_lat != want_lat) begin bad++;
                $display("FAIL rnd%0d_latency instr=%h got=%0d want=%0d", n, ins, obs_lat, want_lat); end
            total++; if ({obs_data, obs_rd, obs_ill} !== {eres, (eill ? 5'd0 : ins[11:7]), eill}) begin bad++;
                $display("FAIL rnd%0d_result instr=%h got data=%h rd=%0d ill=%b want data=%h ill=%b", n, ins, obs_data, obs_rd, obs_ill, eres, eill); end
            if (!eill) begin
                total++; if (obs_flags !== flag_of(eres)) begin bad++;
                    $display("FAIL rnd%0d_flags got=%h want=%h", n, obs_flags, flag_of(eres)); end
            end
            total++; if (obs_nonidle != 0 || obs_unstable != 0) begin bad++;
                $display("FAIL rnd%0d_hold got nonidle=%0d unstable=%0d want 0/0", n, obs_nonidle, obs_unstable); end
            total++; if ({obs_done_vld, obs_done_rdy} !== 2'b01) begin bad++;
                $display("FAIL rnd%0d_handshake got=%b want=01", n, {obs_done_vld, obs_done_rdy}); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_exec();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
